// File: rtl/uart_tx_fifo_if.sv
// Byte-queue handshake and serial-side status bundle for uart_tx_fifo.
// The DUT attaches through the slave modport; the host side uses master.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          tx_dv;
   logic [7:0]    tx_byte;
   logic          tx_ready;
   logic          tx_serial;
   logic          tx_active;
   logic          tx_done;
   logic [CW-1:0] fifo_count;

   modport master (
      output tx_dv, tx_byte,
      input  tx_ready, tx_serial, tx_active, tx_done, fifo_count
   );

   modport slave (
      input  tx_dv, tx_byte,
      output tx_ready, tx_serial, tx_active, tx_done, fifo_count
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fronted by a small circular byte FIFO.
// Frames go out back-to-back with no idle gap while bytes are queued.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input logic           i_Clock,
   input logic           i_Reset,
   uart_tx_fifo_if.slave tx
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int KW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic [KW-1:0] clk_cnt, clk_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift_reg, shift_n;
   logic          serial, serial_n;
   logic          active, active_n;
   logic          done, done_n;
   logic          bit_end;

   // Ready looks only at count, so a push into a full FIFO is dropped even if
   // a pop happens on the same edge.
   assign push    = tx.tx_dv && (count != FULL);
   assign bit_end = (clk_cnt == K_LAST);

   always_ff @(posedge i_Clock) begin
      if (push) mem[wr_ptr] <= tx.tx_byte;
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         serial    <= 1'b1;
         active    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         clk_cnt   <= clk_n;
         bit_idx   <= bit_n;
         shift_reg <= shift_n;
         serial    <= serial_n;
         active    <= active_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      clk_n   = clk_cnt;
      bit_n   = bit_idx;
      shift_n = shift_reg;
      pop     = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               clk_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               clk_n   = '0;
               bit_n   = '0;
               state_n = DATA;
            end else begin
               clk_n = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               clk_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end else begin
               clk_n = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               done_n = 1'b1;
               clk_n  = '0;
               // Chain straight into the next start bit when more data is queued.
               if (count != '0) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               clk_n = clk_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Line level is computed from the next state so the flop output lines up
      // with the state it belongs to.
      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[bit_n];
         default: serial_n = 1'b1;
      endcase
      active_n = (state_n != IDLE);
   end

   assign tx.tx_ready   = (count != FULL);
   assign tx.tx_serial  = serial;
   assign tx.tx_active  = active;
   assign tx.tx_done    = done;
   assign tx.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle-exact waveform checks at 217 and
// 4 clocks per bit, loopback decode, back-to-back, overflow and mid-frame reset.
module tb_uart_tx_fifo;
   localparam int CPB = 217;
   localparam int CPS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #20 clk = ~clk;

   uart_tx_fifo_if #(.FIFO_DEPTH(4)) ifl ();
   uart_tx_fifo_if #(.FIFO_DEPTH(4)) ifs ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .tx      (ifl)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(CPS), .FIFO_DEPTH(4)) dut_s (
      .i_Clock (clk),
      .i_Reset (rst),
      .tx      (ifs)
   );

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] wb [8];
   int         wn     = 0;
   logic       w_first;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
   endtask

   // Expected line for wn queued bytes wb[] sent back-to-back, starting at the
   // first negedge after this task is entered (first start-bit cycle).
   task automatic wave(input string tag, input bit sm, input int cpb);
      int fl, total, err, act, nd;
      fl    = 10 * cpb;
      total = wn * fl;
      err   = 0;
      act   = 0;
      nd    = 0;
      for (int t = 0; t <= total + 2 * cpb; t++) begin
         int   f, b;
         logic es, ea, ed, s, a, d;
         @(negedge clk);
         s = sm ? ifs.tx_serial : ifl.tx_serial;
         a = sm ? ifs.tx_active : ifl.tx_active;
         d = sm ? ifs.tx_done   : ifl.tx_done;
         f = t / fl;
         b = (t % fl) / cpb;
         if (f >= wn) begin
            es = 1'b1;
            ea = 1'b0;
         end else begin
            ea = 1'b1;
            if (b == 0)      es = 1'b0;
            else if (b == 9) es = 1'b1;
            else             es = wb[f][b-1];
         end
         ed = (t > 0) && (t % fl == 0) && (f <= wn);
         if (t == 0) w_first = s;
         if (s !== es || a !== ea || d !== ed) err++;
         if (a === 1'b1) act++;
         if (d === 1'b1) nd++;
      end
      chk({tag, "_wave_errs"}, 32'(err), 32'd0);
      chk({tag, "_active_cycles"}, 32'(act), 32'(total));
      chk({tag, "_done_pulses"}, 32'(nd), 32'(wn));
   endtask

   // Mid-bit sampling receiver on the 217-clock line.
   task automatic rx_byte(output logic [7:0] b, output logic ok);
      int n;
      n  = 0;
      ok = 1'b0;
      b  = '0;
      do begin
         @(negedge clk);
         n++;
      end while (ifl.tx_serial !== 1'b0 && n < 30 * CPB);
      if (n >= 30 * CPB) return;
      repeat (CPB / 2) @(negedge clk);
      if (ifl.tx_serial !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = ifl.tx_serial;
      end
      repeat (CPB) @(negedge clk);
      ok = (ifl.tx_serial === 1'b1);
   endtask

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b0, b1;
      logic       ok0, ok1;
      int         err;

      ifl.tx_dv = 1'b0; ifl.tx_byte = '0;
      ifs.tx_dv = 1'b0; ifs.tx_byte = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_serial", 32'(ifl.tx_serial), 32'd1);
      chk("rst_active", 32'(ifl.tx_active), 32'd0);
      chk("rst_done",   32'(ifl.tx_done),   32'd0);
      chk("rst_count",  32'(ifl.fifo_count), 32'd0);
      chk("rst_ready",  32'(ifl.tx_ready),  32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Single byte 0x37: bits 1,1,1,0,1,1,0,0 LSB first.
      ifl.tx_dv = 1'b1; ifl.tx_byte = 8'h37;
      @(negedge clk);
      ifl.tx_dv = 1'b0; ifl.tx_byte = 8'hC8;
      chk("one_count_after_push", 32'(ifl.fifo_count), 32'd1);
      chk("one_serial_before_pop", 32'(ifl.tx_serial), 32'd1);
      wb[0] = 8'h37; wn = 1;
      wave("one", 1'b0, CPB);
      chk("one_first_low", 32'(w_first), 32'd0);

      // Loopback decode of two queued bytes.
      ifl.tx_dv = 1'b1; ifl.tx_byte = 8'h37;
      @(negedge clk);
      ifl.tx_byte = 8'h19;
      @(negedge clk);
      ifl.tx_dv = 1'b0; ifl.tx_byte = 8'h00;
      rx_byte(b0, ok0);
      rx_byte(b1, ok1);
      chk("lb_byte0", 32'(b0), 32'h37);
      chk("lb_byte1", 32'(b1), 32'h19);
      chk("lb_framing", 32'(ok0 & ok1), 32'd1);
      repeat (CPB) @(negedge clk);
      chk("lb_idle_active", 32'(ifl.tx_active), 32'd0);

      // Back-to-back pushes, then fill to full and try one more (dropped).
      ifl.tx_dv = 1'b1; ifl.tx_byte = 8'hA5;
      wb[0] = 8'hA5; wb[1] = 8'h00; wb[2] = 8'hFF; wb[3] = 8'h5A; wb[4] = 8'hC7;
      wn = 5;
      fork
         begin
            @(negedge clk); ifl.tx_byte = 8'h00;
            @(negedge clk); ifl.tx_byte = 8'hFF;
            @(negedge clk); ifl.tx_byte = 8'h5A;
            @(negedge clk);
            chk("b2b_count_4push", 32'(ifl.fifo_count), 32'd3);
            chk("b2b_ready_4push", 32'(ifl.tx_ready), 32'd1);
            ifl.tx_byte = 8'hC7;
            @(negedge clk);
            chk("full_count", 32'(ifl.fifo_count), 32'd4);
            chk("full_ready", 32'(ifl.tx_ready), 32'd0);
            ifl.tx_byte = 8'h11;
            @(negedge clk);
            chk("ovf_count", 32'(ifl.fifo_count), 32'd4);
            ifl.tx_dv = 1'b0; ifl.tx_byte = 8'hEE;
         end
         begin
            @(negedge clk);
            wave("b2b", 1'b0, CPB);
         end
      join
      chk("b2b_end_count", 32'(ifl.fifo_count), 32'd0);

      // Reset during bit 3 of 0xC3 with two more bytes queued.
      ifl.tx_dv = 1'b1; ifl.tx_byte = 8'hC3;
      @(negedge clk); ifl.tx_byte = 8'h44;
      @(negedge clk); ifl.tx_byte = 8'h55;
      @(negedge clk); ifl.tx_dv = 1'b0;
      chk("mid_queued", 32'(ifl.fifo_count), 32'd2);
      repeat (4 * CPB + 99) @(negedge clk);
      chk("mid_bit3", 32'(ifl.tx_serial), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_serial", 32'(ifl.tx_serial), 32'd1);
      chk("mid_rst_count",  32'(ifl.fifo_count), 32'd0);
      chk("mid_rst_active", 32'(ifl.tx_active), 32'd0);
      chk("mid_rst_ready",  32'(ifl.tx_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      err = 0;
      repeat (12 * CPB) begin
         @(negedge clk);
         if (ifl.tx_serial !== 1'b1 || ifl.tx_active !== 1'b0 || ifl.tx_done !== 1'b0) err++;
      end
      chk("mid_no_frames", 32'(err), 32'd0);
      ifl.tx_dv = 1'b1; ifl.tx_byte = 8'h81;
      @(negedge clk);
      ifl.tx_dv = 1'b0;
      wb[0] = 8'h81; wn = 1;
      wave("post_rst", 1'b0, CPB);

      // Short bit period.
      ifs.tx_dv = 1'b1; ifs.tx_byte = 8'h01;
      @(negedge clk);
      ifs.tx_dv = 1'b0; ifs.tx_byte = 8'hFE;
      chk("short_count", 32'(ifs.fifo_count), 32'd1);
      wb[0] = 8'h01; wn = 1;
      wave("short", 1'b1, CPS);
      chk("short_first_low", 32'(w_first), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
